// File: rtl/mem_lane_arbiter_if.sv
// SRAM-like memory port (req / addr_ok / data_ok) shared by mem_lane_arbiter
// (master) and the memory or bus bridge behind it (slave).
interface mem_lane_arbiter_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic              mem_wr;
    logic [5:0]        mem_op;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_op, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_op, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/mem_lane_arbiter.sv
// E-stage memory arbiter for a multi-issue core: checks alignment, gates lanes
// behind earlier exceptions, serialises surviving ops in lane order onto one
// SRAM-like port and steers returning data back to its lane via a tag FIFO.
// Optional LL/SC link-bit tracking is enabled with `define MEM_ARB_LLSC_EN.
module mem_lane_arbiter #(
    parameter int LANES       = 2,
    parameter int OUTSTANDING = 2,
    parameter int DATA_W      = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [LANES-1:0]         E_exp,
    input  logic [LANES-1:0]         E_mem_en,
    input  logic [LANES-1:0]         E_mem_ren,
    input  logic [LANES-1:0]         E_mem_wen,
    input  logic [6*LANES-1:0]       E_mem_op,
    input  logic [DATA_W*LANES-1:0]  E_mem_addr,
    input  logic [DATA_W*LANES-1:0]  E_mem_wdata,
    output logic [LANES-1:0]         E_mem_adel,
    output logic [LANES-1:0]         E_mem_ades,
    output logic [LANES-1:0]         E_mem_sel,
    output logic                     stall,
    output logic [DATA_W*LANES-1:0]  M_mem_rdata,
    output logic [LANES-1:0]         M_mem_valid,
    mem_lane_arbiter_if.master       mem
);
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;
    localparam logic [5:0] OP_LL  = 6'h30;
    localparam logic [5:0] OP_SC  = 6'h38;

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
    localparam int CW = $clog2(OUTSTANDING + 1);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic [LW-1:0] lane;
        logic          discard;
        logic          sc;
    } tag_t;

    logic [5:0]        op_l    [LANES];
    logic [DATA_W-1:0] addr_l  [LANES];
    logic [DATA_W-1:0] wdata_l [LANES];
    logic [LANES-1:0]  adel, ades, sel, sc_fail;
    logic [LANES-1:0]  pend, pend_q, pend_left, issue_oh;
    logic [LW-1:0]     issue_lane;
    logic              found;
    state_t            state, state_next;
    tag_t              fifo [OUTSTANDING];
    tag_t              new_tag, head;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_next;
    logic              full, accept, pop, start, done, head_discard;
    logic [DATA_W-1:0] pop_data;
    logic [DATA_W-1:0] rdata_q [LANES];
    logic [LANES-1:0]  valid_q;
    logic              unused_ren;
`ifdef MEM_ARB_LLSC_EN
    localparam logic [5:0] OP_SB = 6'h28;
    logic              llbit;
`endif

    // Read enables carry no information beyond the op code here.
    assign unused_ren = ^E_mem_ren;
    assign full       = (count == CW'(OUTSTANDING));

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    // Per-lane alignment checks; a blocked lane kills itself and every higher lane.
    always_comb begin
        logic kill;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        kill    = 1'b0;
        adel    = '0;
        ades    = '0;
        sel     = '0;
        sc_fail = '0;
        for (int i = 0; i < LANES; i++) begin
            op_l[i]    = E_mem_op[6*i +: 6];
            addr_l[i]  = E_mem_addr[DATA_W*i +: DATA_W];
            wdata_l[i] = E_mem_wdata[DATA_W*i +: DATA_W];
            adel[i] = ((op_l[i] == OP_LW || op_l[i] == OP_LL) && addr_l[i][1:0] != 2'b00) ||
                      ((op_l[i] == OP_LH || op_l[i] == OP_LHU) && addr_l[i][0]);
            ades[i] = ((op_l[i] == OP_SW || op_l[i] == OP_SC) && addr_l[i][1:0] != 2'b00) ||
                      (op_l[i] == OP_SH && addr_l[i][0]);
            kill    = kill | E_exp[i] | adel[i] | ades[i];
            sel[i]  = E_mem_en[i] & ~kill;
`ifdef MEM_ARB_LLSC_EN
            // A store-conditional without a live link completes locally with no request.
            sc_fail[i] = sel[i] & (op_l[i] == OP_SC) & ~llbit;
`endif
        end
    end

    assign E_mem_adel = adel;
    assign E_mem_ades = ades;
    assign E_mem_sel  = sel;

    // Present the lowest pending lane on the memory port.
    always_comb begin
        pend = (state == IDLE) ? ((rst || flush) ? '0 : (sel & ~sc_fail)) : pend_q;
        issue_oh   = '0;
        issue_lane = '0;
        found      = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (pend[i] && !found) begin
                issue_oh[i] = 1'b1;
                issue_lane  = LW'(i);
                found       = 1'b1;
            end
        end
        mem.mem_req   = found & ~full & ~flush & ~rst;
        mem.mem_wr    = 1'b0;
        mem.mem_op    = '0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        if (found) begin
            mem.mem_wr    = E_mem_wen[issue_lane];
            mem.mem_addr  = addr_l[issue_lane];
            mem.mem_wdata = wdata_l[issue_lane];
            // LL/SC look like plain word accesses to the memory.
            case (op_l[issue_lane])
                OP_SC:   mem.mem_op = OP_SW;
                OP_LL:   mem.mem_op = OP_LW;
                default: mem.mem_op = op_l[issue_lane];
            endcase
        end
    end

    // Accept/response bookkeeping and next-state; stall while the group is unfinished.
    always_comb begin
        accept       = mem.mem_req & mem.mem_addr_ok;
        new_tag.lane    = issue_lane;
        new_tag.discard = 1'b0;
        new_tag.sc      = (op_l[issue_lane] == OP_SC);
        // With an empty FIFO a same-cycle data_ok belongs to the request being pushed.
        pop          = mem.mem_data_ok & ((count != '0) | accept);
        head         = (count != '0) ? fifo[rd_ptr] : new_tag;
        head_discard = head.discard | flush;
        pop_data     = head.sc ? DATA_W'(1) : mem.mem_rdata;
        count_next   = count + CW'(accept) - CW'(pop);
        pend_left    = flush ? '0 : (pend & ~(accept ? issue_oh : '0));
        done         = (pend_left == '0) && (count_next == '0);
        start        = (state == IDLE) && (sel != '0) && !flush && !rst;
        state_next   = state;
        case (state)
            IDLE:    if (start && !done) state_next = BUSY;
            BUSY:    if (done)           state_next = IDLE;
            default:                     state_next = IDLE;
        endcase
        // Stall drops on the completing cycle so the held group is not replayed.
        stall = ~rst & (state_next == BUSY);
    end

    // FSM state and remaining-lane mask.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state  <= IDLE;
            pend_q <= '0;
        end else begin
            state  <= state_next;
            pend_q <= (state_next == BUSY) ? pend_left : '0;
        end
    end

    // Tag FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (accept) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)    rd_ptr <= ptr_inc(rd_ptr);
            count <= count_next;
        end
    end

    // Tag FIFO storage; a flush marks everything in flight as discard.
    always_ff @(posedge clk) begin
        // NOTE: tag storage is not reset; count alone decides which entries are live.
        if (flush) begin
            for (int k = 0; k < OUTSTANDING; k++) fifo[k].discard <= 1'b1;
        end
        if (accept) fifo[wr_ptr] <= new_tag;
    end

    // Per-lane result capture, cleared when a group starts or is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LANES; i++) rdata_q[i] <= '0;
            valid_q <= '0;
        end else begin
            if (start || flush) begin
                for (int i = 0; i < LANES; i++) rdata_q[i] <= '0;
                valid_q <= start ? sc_fail : '0;
            end
            if (pop && !head_discard) begin
                rdata_q[head.lane] <= pop_data;
                valid_q[head.lane] <= 1'b1;
            end
        end
    end

`ifdef MEM_ARB_LLSC_EN
    // LL/SC link bit: set by an accepted LL, cleared by any accepted store.
    always_ff @(posedge clk) begin
        if (rst) begin
            llbit <= 1'b0;
        end else if (accept) begin
            if (op_l[issue_lane] == OP_LL) llbit <= 1'b1;
            else if (op_l[issue_lane] inside {OP_SW, OP_SH, OP_SB, OP_SC}) llbit <= 1'b0;
        end
    end
`endif

    // Hold results of the last group; unselected lanes read as zero.
    always_comb begin
        M_mem_rdata = '0;
        for (int i = 0; i < LANES; i++) begin
            M_mem_rdata[DATA_W*i +: DATA_W] = valid_q[i] ? rdata_q[i] : '0;
        end
    end

    assign M_mem_valid = valid_q;
endmodule

// File: tb/tb_mem_lane_arbiter.sv
// Directed bench for mem_lane_arbiter: a default instance (OUTSTANDING=2) and
// a second instance with OUTSTANDING=1 for the FIFO-full and flush cases.
module tb_mem_lane_arbiter;
    localparam logic [5:0] OP_LH = 6'h21;
    localparam logic [5:0] OP_LW = 6'h23;
    localparam logic [5:0] OP_SW = 6'h2b;
    localparam logic [5:0] OP_LL = 6'h30;
    localparam logic [5:0] OP_SC = 6'h38;

    logic        clk = 1'b0;
    logic        rst, flush, flush1;
    logic [1:0]  exp_v, en, en1, ren, wen;
    logic [11:0] op;
    logic [63:0] addr, wdata;

    logic [1:0]  adel0, ades0, sel0, valid0;
    logic [1:0]  adel1, ades1, sel1, valid1;
    logic        stall0, stall1;
    logic [63:0] rdata0, rdata1;

    int total = 0;
    int bad   = 0;

    mem_lane_arbiter_if #(.DATA_W(32)) m0 ();
    mem_lane_arbiter_if #(.DATA_W(32)) m1 ();

    mem_lane_arbiter #(.LANES(2), .OUTSTANDING(2), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .E_exp(exp_v),
        .E_mem_en(en), .E_mem_ren(ren), .E_mem_wen(wen), .E_mem_op(op),
        .E_mem_addr(addr), .E_mem_wdata(wdata),
        .E_mem_adel(adel0), .E_mem_ades(ades0), .E_mem_sel(sel0),
        .stall(stall0), .M_mem_rdata(rdata0), .M_mem_valid(valid0), .mem(m0)
    );

    mem_lane_arbiter #(.LANES(2), .OUTSTANDING(1), .DATA_W(32)) dut1 (
        .clk(clk), .rst(rst), .flush(flush1), .E_exp(exp_v),
        .E_mem_en(en1), .E_mem_ren(ren), .E_mem_wen(wen), .E_mem_op(op),
        .E_mem_addr(addr), .E_mem_wdata(wdata),
        .E_mem_adel(adel1), .E_mem_ades(ades1), .E_mem_sel(sel1),
        .stall(stall1), .M_mem_rdata(rdata1), .M_mem_valid(valid1), .mem(m1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic set_lane(input int i, input logic e, input logic r, input logic w,
                            input logic [5:0] o, input logic [31:0] a, input logic [31:0] d);
        en[i]             = e;
        ren[i]            = r;
        wen[i]            = w;
        op[6*i +: 6]      = o;
        addr[32*i +: 32]  = a;
        wdata[32*i +: 32] = d;
    endtask

    task automatic mem0(input logic aok, input logic dok, input logic [31:0] rd);
        m0.mem_addr_ok = aok;
        m0.mem_data_ok = dok;
        m0.mem_rdata   = rd;
    endtask

    task automatic clear_all();
        exp_v = '0; en = '0; en1 = '0; ren = '0; wen = '0;
        op = '0; addr = '0; wdata = '0;
        flush = 1'b0; flush1 = 1'b0;
        mem0(1'b0, 1'b0, 32'h0);
        m1.mem_addr_ok = 1'b0;
        m1.mem_data_ok = 1'b0;
        m1.mem_rdata   = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        clear_all();

        // Reset state
        tick(); tick();
        at_neg();
        chk("rst_stall", stall0, 1'b0);
        chk("rst_req",   m0.mem_req, 1'b0);
        chk("rst_valid", valid0, 2'b00);
        chk("rst_rdata", rdata0, 64'h0);
        tick();
        rst = 1'b0;

        // Lane0 LW, zero-wait memory: no stall, data lands in lane0
        set_lane(0, 1, 1, 0, OP_LW, 32'h8000_1000, 32'h0);
        mem0(1'b1, 1'b1, 32'h1234_5678);
        at_neg();
        chk("zw_req",   m0.mem_req, 1'b1);
        chk("zw_addr",  m0.mem_addr, 32'h8000_1000);
        chk("zw_wr",    m0.mem_wr, 1'b0);
        chk("zw_op",    m0.mem_op, OP_LW);
        chk("zw_stall", stall0, 1'b0);
        chk("zw_sel",   sel0, 2'b01);
        tick();
        clear_all();
        at_neg();
        chk("zw_valid",  valid0, 2'b01);
        chk("zw_rdata",  rdata0, 64'h0000_0000_1234_5678);
        chk("zw_req_off", m0.mem_req, 1'b0);
        tick();

        // Two loads, addr_ok one cycle late, data_ok two cycles after accept
        set_lane(0, 1, 1, 0, OP_LW, 32'h100, 32'h0);
        set_lane(1, 1, 1, 0, OP_LW, 32'h104, 32'h0);
        at_neg();
        chk("dl_c0_req",   m0.mem_req, 1'b1);
        chk("dl_c0_addr",  m0.mem_addr, 32'h100);
        chk("dl_c0_stall", stall0, 1'b1);
        tick();
        mem0(1'b1, 1'b0, 32'h0);
        at_neg();
        chk("dl_c1_addr",  m0.mem_addr, 32'h100);
        chk("dl_c1_stall", stall0, 1'b1);
        tick();
        mem0(1'b0, 1'b0, 32'h0);
        at_neg();
        chk("dl_c2_req",   m0.mem_req, 1'b1);
        chk("dl_c2_addr",  m0.mem_addr, 32'h104);
        chk("dl_c2_valid", valid0, 2'b00);
        chk("dl_c2_stall", stall0, 1'b1);
        tick();
        mem0(1'b1, 1'b1, 32'h0000_00a0);
        at_neg();
        chk("dl_c3_addr",  m0.mem_addr, 32'h104);
        chk("dl_c3_stall", stall0, 1'b1);
        tick();
        mem0(1'b0, 1'b0, 32'h0);
        at_neg();
        chk("dl_c4_req",   m0.mem_req, 1'b0);
        chk("dl_c4_stall", stall0, 1'b1);
        chk("dl_c4_valid", valid0, 2'b01);
        chk("dl_c4_rdata", rdata0, 64'h0000_0000_0000_00a0);
        tick();
        mem0(1'b0, 1'b1, 32'h0000_00b1);
        tick();
        clear_all();
        at_neg();
        chk("dl_end_stall", stall0, 1'b0);
        chk("dl_end_valid", valid0, 2'b11);
        chk("dl_end_rdata", rdata0, 64'h0000_00b1_0000_00a0);
        chk("dl_end_req",   m0.mem_req, 1'b0);
        tick();

        // Exception on lane0 kills both; exception on lane1 leaves lane0
        set_lane(0, 1, 1, 0, OP_LW, 32'h100, 32'h0);
        set_lane(1, 1, 1, 0, OP_LW, 32'h104, 32'h0);
        exp_v = 2'b01;
        at_neg();
        chk("ex0_sel",   sel0, 2'b00);
        chk("ex0_req",   m0.mem_req, 1'b0);
        chk("ex0_stall", stall0, 1'b0);
        tick();
        exp_v = 2'b10;
        mem0(1'b1, 1'b1, 32'h0000_0055);
        at_neg();
        chk("ex1_sel",   sel0, 2'b01);
        chk("ex1_req",   m0.mem_req, 1'b1);
        chk("ex1_addr",  m0.mem_addr, 32'h100);
        chk("ex1_stall", stall0, 1'b0);
        tick();
        clear_all();
        at_neg();
        chk("ex1_valid", valid0, 2'b01);
        chk("ex1_rdata", rdata0, 64'h0000_0000_0000_0055);
        tick();

        // Misaligned LH on lane0 kills both lanes
        set_lane(0, 1, 1, 0, OP_LH, 32'h101, 32'h0);
        set_lane(1, 1, 1, 0, OP_LW, 32'h104, 32'h0);
        at_neg();
        chk("adel_adel",  adel0, 2'b01);
        chk("adel_ades",  ades0, 2'b00);
        chk("adel_sel",   sel0, 2'b00);
        chk("adel_req",   m0.mem_req, 1'b0);
        chk("adel_stall", stall0, 1'b0);
        tick();
        // Misaligned SW on lane1 with clean lane0
        set_lane(0, 1, 1, 0, OP_LW, 32'h100, 32'h0);
        set_lane(1, 1, 0, 1, OP_SW, 32'h102, 32'h0);
        mem0(1'b1, 1'b1, 32'h0000_0066);
        at_neg();
        chk("ades_ades", ades0, 2'b10);
        chk("ades_adel", adel0, 2'b00);
        chk("ades_sel",  sel0, 2'b01);
        chk("ades_req",  m0.mem_req, 1'b1);
        tick();
        clear_all();
        at_neg();
        chk("ades_valid", valid0, 2'b01);
        chk("ades_rdata", rdata0, 64'h0000_0000_0000_0066);
        tick();

        // Store presents write data with mem_wr set
        set_lane(0, 1, 0, 1, OP_SW, 32'h200, 32'hdead_beef);
        mem0(1'b1, 1'b1, 32'h0);
        at_neg();
        chk("sw_req",   m0.mem_req, 1'b1);
        chk("sw_wr",    m0.mem_wr, 1'b1);
        chk("sw_op",    m0.mem_op, OP_SW);
        chk("sw_wdata", m0.mem_wdata, 32'hdead_beef);
        chk("sw_stall", stall0, 1'b0);
        tick();
        clear_all();
        tick();

`ifdef MEM_ARB_LLSC_EN
        // LL then SC to the same word: SC writes and returns 1
        set_lane(0, 1, 1, 0, OP_LL, 32'h200, 32'h0);
        mem0(1'b1, 1'b1, 32'h0000_00ab);
        at_neg();
        chk("ll_op", m0.mem_op, OP_LW);
        tick();
        clear_all();
        set_lane(0, 1, 0, 1, OP_SC, 32'h200, 32'h0000_0011);
        mem0(1'b1, 1'b1, 32'h0000_0077);
        at_neg();
        chk("sc_ok_req", m0.mem_req, 1'b1);
        chk("sc_ok_op",  m0.mem_op, OP_SW);
        chk("sc_ok_wr",  m0.mem_wr, 1'b1);
        tick();
        clear_all();
        at_neg();
        chk("sc_ok_valid", valid0, 2'b01);
        chk("sc_ok_rdata", rdata0, 64'h1);
        tick();
        // LL, SW, SC: the store breaks the link, SC issues nothing and returns 0
        set_lane(0, 1, 1, 0, OP_LL, 32'h300, 32'h0);
        mem0(1'b1, 1'b1, 32'h0);
        tick();
        clear_all();
        set_lane(0, 1, 0, 1, OP_SW, 32'h304, 32'h0);
        mem0(1'b1, 1'b1, 32'h0);
        tick();
        clear_all();
        set_lane(0, 1, 0, 1, OP_SC, 32'h300, 32'h0000_0022);
        at_neg();
        chk("sc_bad_req",   m0.mem_req, 1'b0);
        chk("sc_bad_stall", stall0, 1'b0);
        chk("sc_bad_sel",   sel0, 2'b01);
        tick();
        clear_all();
        at_neg();
        chk("sc_bad_valid", valid0, 2'b01);
        chk("sc_bad_rdata", rdata0, 64'h0);
        tick();
`else
        // Without link tracking SC is a word store returning 1, LL a plain LW
        set_lane(0, 1, 0, 1, OP_SC, 32'h204, 32'h0000_0011);
        mem0(1'b1, 1'b1, 32'h0000_0077);
        at_neg();
        chk("sc_req", m0.mem_req, 1'b1);
        chk("sc_op",  m0.mem_op, OP_SW);
        chk("sc_wr",  m0.mem_wr, 1'b1);
        tick();
        clear_all();
        at_neg();
        chk("sc_valid", valid0, 2'b01);
        chk("sc_rdata", rdata0, 64'h1);
        tick();
        set_lane(0, 1, 1, 0, OP_LL, 32'h208, 32'h0);
        mem0(1'b1, 1'b1, 32'h0000_0099);
        at_neg();
        chk("ll_op",  m0.mem_op, OP_LW);
        chk("ll_req", m0.mem_req, 1'b1);
        tick();
        clear_all();
        at_neg();
        chk("ll_rdata", rdata0, 64'h0000_0000_0000_0099);
        tick();
`endif

        // OUTSTANDING=1: second request waits for the first pop, then a flush
        set_lane(0, 1, 1, 0, OP_LW, 32'h100, 32'h0);
        set_lane(1, 1, 1, 0, OP_LW, 32'h104, 32'h0);
        en1 = 2'b11;
        en  = 2'b00;
        m1.mem_addr_ok = 1'b1;
        at_neg();
        chk("o1_c0_req",   m1.mem_req, 1'b1);
        chk("o1_c0_addr",  m1.mem_addr, 32'h100);
        chk("o1_c0_stall", stall1, 1'b1);
        tick();
        at_neg();
        chk("o1_c1_req",   m1.mem_req, 1'b0);
        chk("o1_c1_stall", stall1, 1'b1);
        tick();
        at_neg();
        chk("o1_c2_req", m1.mem_req, 1'b0);
        tick();
        m1.mem_data_ok = 1'b1;
        m1.mem_rdata   = 32'h0000_00c0;
        at_neg();
        chk("o1_c3_req", m1.mem_req, 1'b0);
        tick();
        m1.mem_data_ok = 1'b0;
        at_neg();
        chk("o1_c4_req",   m1.mem_req, 1'b1);
        chk("o1_c4_addr",  m1.mem_addr, 32'h104);
        chk("o1_c4_valid", valid1, 2'b01);
        chk("o1_c4_rdata", rdata1, 64'h0000_0000_0000_00c0);
        tick();
        m1.mem_addr_ok = 1'b0;
        flush1 = 1'b1;
        at_neg();
        chk("o1_fl_req",   m1.mem_req, 1'b0);
        chk("o1_fl_stall", stall1, 1'b1);
        tick();
        flush1 = 1'b0;
        en1    = 2'b00;
        at_neg();
        chk("o1_drain_stall", stall1, 1'b1);
        chk("o1_drain_valid", valid1, 2'b00);
        chk("o1_drain_req",   m1.mem_req, 1'b0);
        tick();
        m1.mem_data_ok = 1'b1;
        m1.mem_rdata   = 32'h0000_00d1;
        tick();
        m1.mem_data_ok = 1'b0;
        at_neg();
        chk("o1_end_stall", stall1, 1'b0);
        chk("o1_end_valid", valid1, 2'b00);
        chk("o1_end_rdata", rdata1, 64'h0);
        chk("o1_end_req",   m1.mem_req, 1'b0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
